// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Shares a single APB master port between NUM_REQ internal requesters.
// Requests are granted round-robin, and exactly one APB transfer is in flight
// at a time. The block drives the SETUP/ACCESS phases, waits on pready, and
// returns read data or completion to the requester that was granted.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   defined   - an ACCESS phase that waits TIMEOUT_CYCLES cycles with pready=0
//               is aborted, and the requester gets rsp_valid with rsp_err=1.
//   undefined - ACCESS waits indefinitely and rsp_err is constant 0.
//
// Handshake semantics (all requester-side signals):
//   A request is accepted in the cycle where req_valid[i]=1 and req_ready[i]=1.
//   req_ready is a combinational one-hot pulse that lasts one cycle. It is only
//   raised for a requester whose req_valid is high. A requester may drop
//   req_valid at any time without a handshake; a request that is not accepted
//   is simply not accepted. rsp_valid is a one-hot, one-cycle pulse with
//   rsp_rdata/rsp_err, and it cannot be back-pressured.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/ready/write per-requester request handshake and direction
//   req_addr, req_wdata   flattened per-requester address / write data
//   rsp_valid             one-hot completion pulse
//   rsp_rdata, rsp_err    read data / timeout flag, qualified by rsp_valid
//   paddr..pwdata         APB master request outputs
//   prdata, pready        APB slave response inputs
//   dbg_state             current FSM state (0=IDLE, 1=SETUP, 2=ACCESS)
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_W-1:0]          paddr,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q;     // round-robin search start
  logic [IDX_W-1:0]    gnt_q;     // requester owning the current transfer
  logic [IDX_W-1:0]    win;
  logic [IDX_W:0]      cand;      // one extra bit so ptr+k can wrap
  logic                win_found;
  logic                arb_en;
  logic                grant;
  logic                done;
  logic                timeout_hit;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;

  // ---------------------------------------------------------------------------
  // Round-robin search: first asserted req_valid from ptr_q upward, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win       = cand[IDX_W-1:0];
      end
    end
  end

  // Winner's request fields, selected with constant slice positions.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  // A new request may be taken when the bus is idle, or in the completing
  // ACCESS cycle so the next SETUP follows with no idle gap.
  assign arb_en    = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready);
  assign grant     = arb_en && win_found;
  assign done      = (state_q == ST_ACCESS) && pready;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  // ---------------------------------------------------------------------------
  // Optional ACCESS-phase watchdog.
  // ---------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      to_cnt_q <= '0;
    end else if ((state_q == ST_ACCESS) && !pready && !timeout_hit) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  // pready=1 in the limit cycle wins: that is a normal completion.
  assign timeout_hit = (state_q == ST_ACCESS) && !pready &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready)           state_d = grant ? ST_SETUP : ST_IDLE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // psel/penable are decoded straight from the state register, so an
  // asynchronous reset clears them immediately.
  always_comb begin
    psel      = (state_q != ST_IDLE);
    penable   = (state_q == ST_ACCESS);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping and APB request registers. They hold in IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (grant) begin
      ptr_q  <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
      gnt_q  <= win;
      paddr  <= sel_addr;
      pwrite <= sel_write;
      pwdata <= sel_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response. gnt_q still names the finishing requester here even when a
  // back-to-back grant overwrites it on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (done) begin
        rsp_valid <= NUM_REQ'(1) << gnt_q;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (timeout_hit) begin
        rsp_valid <= NUM_REQ'(1) << gnt_q;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed bench for apb_master_arbiter with NUM_REQ=2. It covers a single
// read, a write with wait states, round-robin contention with back-to-back
// transfers, reset during ACCESS, and ACCESS-phase timeout behaviour. For the
// timeout case, defining APB_TIMEOUT_EN selects TIMEOUT_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic [1:0]      dbg_state;

  int n_run  = 0;
  int n_fail = 0;
  logic [NR-1:0] exp_q[$];

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NR-1:0] prev_g;
    logic [NR-1:0] g_exp;
    logic          ok;

    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b1;
    #12;
    chk("reset_ctrl", {psel, penable, pwrite, req_ready, rsp_valid, rsp_err}, 64'd0);
    chk("reset_paddr", paddr, 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_state", dbg_state, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // ---- 1: single read, pready tied high ----
    prdata          = 32'h0000_00A5;
    req_addr[31:0]  = 32'h0000_0008;
    req_write       = 2'b00;
    req_valid       = 2'b01;
    settle;
    chk("rd_ready_T", req_ready, 64'b01);
    tick;                                   // T+1
    req_valid = 2'b00;
    chk("rd_setup", {psel, penable, pwrite}, 64'b100);
    chk("rd_paddr", paddr, 64'h8);
    tick;                                   // T+2
    chk("rd_access", {psel, penable, rsp_valid}, 64'b1100);
    tick;                                   // T+3
    chk("rd_rsp", {rsp_valid, rsp_err, psel}, 64'b01_0_0);
    chk("rd_rdata", rsp_rdata, 64'hA5);
    tick;
    chk("rd_rsp_pulse", rsp_valid, 64'b00);

    // ---- 2: write from req 1 with 3 wait states ----
    pready            = 1'b0;
    prdata            = 32'hDEAD_BEEF;
    req_addr[63:32]   = 32'h0000_0000;
    req_wdata[63:32]  = 32'h0000_0055;
    req_write         = 2'b10;
    req_valid         = 2'b10;
    settle;
    chk("wr_ready", req_ready, 64'b10);
    tick;
    req_valid = 2'b00;
    chk("wr_setup", {psel, penable, pwrite}, 64'b101);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pready = 1'b1;
      settle;
      chk("wr_access_ctl", {psel, penable, pwrite, rsp_valid}, 64'b111_00);
      chk("wr_access_addr", paddr, 64'h0);
      chk("wr_access_data", pwdata, 64'h55);
      tick;
    end
    chk("wr_rsp", {rsp_valid, rsp_err, psel}, 64'b10_0_0);
    chk("wr_rdata", rsp_rdata, 64'h0);
    tick;

    // ---- 3: contention, both requesters held valid for 4 transfers ----
    prdata          = 32'h0000_0077;
    req_addr[31:0]  = 32'h0000_0010;
    req_addr[63:32] = 32'h0000_0020;
    req_write       = 2'b00;
    req_valid       = 2'b11;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    prev_g = '0;
    for (int g = 0; g < 4; g++) begin
      settle;
      g_exp = exp_q.pop_front();
      chk("cont_grant", req_ready, {62'd0, g_exp});
      tick;                                 // SETUP
      if (g == 3) req_valid = 2'b00;
      chk("cont_setup", {psel, penable}, 64'b10);
      chk("cont_paddr", paddr, g_exp[0] ? 64'h10 : 64'h20);
      if (g > 0) chk("cont_rsp", rsp_valid, {62'd0, prev_g});
      prev_g = g_exp;
      tick;                                 // ACCESS
      chk("cont_access", {psel, penable}, 64'b11);
    end
    settle;
    chk("cont_no_grant", req_ready, 64'b00);
    tick;
    chk("cont_last_rsp", {rsp_valid, psel}, 64'b10_0);
    chk("cont_rdata", rsp_rdata, 64'h77);
    tick;

    // ---- 4: reset during ACCESS ----
    pready           = 1'b0;
    req_addr[31:0]   = 32'h0000_0030;
    req_wdata[31:0]  = 32'h0000_CAFE;
    req_write        = 2'b01;
    req_valid        = 2'b01;
    settle;
    chk("rst_pre_grant", req_ready, 64'b01);
    tick;
    req_valid = 2'b00;
    tick;
    chk("rst_pre_access", {psel, penable, pwrite}, 64'b111);
    chk("rst_pre_pwdata", pwdata, 64'hCAFE);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {psel, penable, pwrite, req_ready, rsp_valid, rsp_err}, 64'd0);
    chk("rst_async_paddr", paddr, 64'd0);
    chk("rst_async_pwdata", pwdata, 64'd0);
    chk("rst_async_rdata", rsp_rdata, 64'd0);
    tick;
    rst_n  = 1'b1;
    pready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (rsp_valid !== 2'b00 || psel !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_rsp", ok, 64'd1);
    req_write = 2'b00;
    req_valid = 2'b11;
    settle;
    chk("rst_ptr_zero", req_ready, 64'b01);
    tick;
    req_valid = 2'b00;
    chk("rst_next_paddr", paddr, 64'h30);
    tick;
    tick;
    chk("rst_next_rsp", rsp_valid, 64'b01);
    chk("rst_next_rdata", rsp_rdata, 64'h77);
    tick;

    // ---- 5: ACCESS-phase timeout ----
    pready            = 1'b0;
    req_addr[63:32]   = 32'h0000_0040;
    req_wdata[63:32]  = 32'h0000_0099;
    req_write         = 2'b10;
    req_valid         = 2'b10;
    settle;
    chk("to_grant", req_ready, 64'b10);
    tick;
    req_valid = 2'b00;
    tick;                                   // first ACCESS cycle
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_access", {psel, penable, rsp_valid}, 64'b11_00);
      tick;
    end
    chk("to_abort", {psel, penable}, 64'b00);
    chk("to_rsp", {rsp_valid, rsp_err}, 64'b10_1);
    chk("to_rdata", rsp_rdata, 64'h0);
    tick;
    chk("to_rsp_pulse", {rsp_valid, rsp_err}, 64'b00_0);
`else
    ok = 1'b1;
    for (int i = 0; i < 110; i++) begin
      if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 2'b00) ok = 1'b0;
      tick;
    end
    chk("no_timeout_hold", ok, 64'd1);
    chk("no_timeout_addr", paddr, 64'h40);
    pready = 1'b1;
    tick;
    chk("no_timeout_rsp", {rsp_valid, rsp_err, psel}, 64'b10_0_0);
    chk("no_timeout_rdata", rsp_rdata, 64'h0);
`endif
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master port (paddr/psel/penable/pwrite/pwdata/prdata/pready) between NUM_REQ internal requesters, for example a register-config sequencer and a FIFO-drain engine driving the UART APB slave.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- Waits on pready and returns read data or completion to the granted requester.
- Only one APB transfer is ever in flight.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester transfer request
req_ready  out  NUM_REQ  one-hot accept pulse to the granted requester
req_write  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice i
req_wdata  in  NUM_REQ*DATA_W  flattened write data
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  timeout error flag, valid with rsp_valid
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready; the slave may hold it low for wait states

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata and rsp_err are all 0.
  - Round-robin pointer is set to 0.
  - Any transfer in flight is dropped with no response.
- FSM has three states: IDLE, SETUP, ACCESS.
- Arbitration runs in IDLE, and in ACCESS in the cycle pready=1. Winner is the first asserted req_valid searching from ptr upward, wrapping at NUM_REQ. req_ready[winner]=1 combinationally for that cycle only. After a grant, ptr = winner+1 mod NUM_REQ.
- Accept (cycle T):
  - At T+1 the FSM is in SETUP with psel=1, penable=0.
  - paddr, pwrite and pwdata are registered from the winner's slices.
- SETUP -> ACCESS unconditionally after one cycle; psel=1, penable=1.
- ACCESS holds until pready=1:
  - paddr, pwrite, pwdata, psel and penable stay stable throughout the wait.
- Completion cycle C (ACCESS with pready=1):
  - At C+1, rsp_valid[granted]=1 for exactly one cycle, with rsp_err=0.
  - rsp_rdata = prdata sampled at C for reads, 0 for writes.
- Next state after completion:
  - If a new request was accepted in C, go to SETUP (back-to-back, no idle cycle). psel stays 1 and penable drops to 0.
  - Otherwise go to IDLE with psel=0, penable=0.
- In IDLE, paddr, pwrite and pwdata hold their last values.
- Minimum latency, accept to rsp_valid: 3 cycles when pready is tied high.
- Requester contract: req_write/addr/wdata stay stable while req_valid=1 until req_ready. req_valid may drop without a handshake; it is never lost-accepted.
- rsp_valid and req_ready may pulse in the same cycle, including for the same requester.
- A requester whose req_valid is deasserted is skipped; no grant is issued when all req_valid=0.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - On reaching TIMEOUT_CYCLES-1 with pready still 0, the transfer is aborted: psel=0, penable=0, FSM goes to IDLE.
  - Next cycle: rsp_valid[granted]=1, rsp_err=1, rsp_rdata=0.
  - pready=1 in the limit cycle is a normal completion.
- Undefined: no counter; ACCESS waits indefinitely and rsp_err is constant 0.

Test Plan:
- Single read, pready tied 1: req 0 reads addr 0x0000_0008, prdata=0x0000_00A5. Expect req_ready[0] at T, SETUP at T+1, ACCESS at T+2, rsp_valid[0] with rsp_rdata=0x0000_00A5 at T+3.
- Write with 3 wait states: req 1 writes 0x55 to 0x0000_0000, pready low for 3 ACCESS cycles. Expect paddr/pwdata/pwrite=1 stable for 4 ACCESS cycles, then rsp_valid[1] with rsp_rdata=0.
- Contention: req 0 and req 1 both held valid for 4 transfers. Expect grants 0,1,0,1, back-to-back with psel never dropping and penable low for exactly one cycle between transfers.
- Reset mid-ACCESS: assert rst_n=0 while psel=1, penable=1. Expect psel, penable and all outputs 0 immediately (asynchronously), no rsp_valid after release, and the next grant goes to req 0.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready held 0. Expect abort after 4 ACCESS cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0. Without the macro, ACCESS persists for 100+ cycles.
